// File: rtl/execute_mdu.sv
// MIPS execute stage with forwarding and ALU, plus an iterative multiply/divide
// unit holding HI/LO and stalling upstream while a result is pending.
module execute_mdu #(
    parameter int len          = 32,
    parameter int NB           = $clog2(len),
    parameter int len_exec_bus = 11,
    parameter int len_mem_bus  = 9,
    parameter int len_wb_bus   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ctrl_clk_mips,
    input  logic [len-1:0]          in_pc_branch,
    input  logic [len-1:0]          in_reg1,
    input  logic [len-1:0]          in_reg2,
    input  logic [len-1:0]          in_sign_extend,
    input  logic [NB-1:0]           in_rs,
    input  logic [NB-1:0]           in_rt,
    input  logic [NB-1:0]           in_rd,
    input  logic [NB-1:0]           in_shamt,
    input  logic [len_exec_bus-1:0] execute_bus,
    input  logic [len_mem_bus-1:0]  memory_bus,
    input  logic [len_wb_bus-1:0]   writeBack_bus,
    input  logic [2:0]              in_mdu_op,
    input  logic                    register_write_3_4,
    input  logic                    register_write_4_5,
    input  logic [NB-1:0]           rd_3_4,
    input  logic [NB-1:0]           rd_4_5,
    input  logic [len-1:0]          in_mem_forw,
    input  logic [len-1:0]          in_wb_forw,
    input  logic                    flush,
    input  logic                    halt_flag_e,
    output logic [len-1:0]          out_pc_branch,
    output logic [len-1:0]          out_alu,
    output logic [len-1:0]          out_reg2,
    output logic                    zero_flag,
    output logic [NB-1:0]           out_write_reg,
    output logic                    out_halt_flag_e,
    output logic [len_mem_bus-1:0]  memory_bus_out,
    output logic [len_wb_bus-1:0]   writeBack_bus_out,
    output logic                    stall_out,
    output logic                    mdu_busy
);
    localparam int CW = $clog2(len + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [len-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic           div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic [len-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res, alu_sel;
    logic [NB-1:0]  wr_sel;
    logic           is_mdu, is_mf, accept, op_signed, sa, sb;
    logic [len:0]   sum, shifted, diff;
    logic [2*len-1:0] prod, prod_n;
    logic           unused_exec;

    assign unused_exec = ^execute_bus[5:4];

    always_comb begin
        fwd_a = in_reg1;
        if (in_rs != '0 && register_write_3_4 && rd_3_4 == in_rs)      fwd_a = in_mem_forw;
        else if (in_rs != '0 && register_write_4_5 && rd_4_5 == in_rs) fwd_a = in_wb_forw;
        fwd_b = in_reg2;
        if (in_rt != '0 && register_write_3_4 && rd_3_4 == in_rt)      fwd_b = in_mem_forw;
        else if (in_rt != '0 && register_write_4_5 && rd_4_5 == in_rt) fwd_b = in_wb_forw;
    end

    assign alu_a = execute_bus[10] ? in_pc_branch :
                   execute_bus[7]  ? {{(len-NB){1'b0}}, in_shamt} : fwd_a;
    assign alu_b = execute_bus[10] ? len'(1) : execute_bus[6] ? in_sign_extend : fwd_b;

    // Shift ops take the amount from A (shamt or rs) and shift B.
    always_comb begin
        case (execute_bus[3:0])
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = alu_a & alu_b;
            4'd3:    alu_res = alu_a | alu_b;
            4'd4:    alu_res = alu_a ^ alu_b;
            4'd5:    alu_res = ~(alu_a | alu_b);
            4'd6:    alu_res = len'($signed(alu_a) < $signed(alu_b));
            4'd7:    alu_res = len'(alu_a < alu_b);
            4'd8:    alu_res = alu_b << alu_a[NB-1:0];
            4'd9:    alu_res = alu_b >> alu_a[NB-1:0];
            4'd10:   alu_res = $signed(alu_b) >>> alu_a[NB-1:0];
            4'd11:   alu_res = {alu_b[len/2-1:0], {(len/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    assign is_mdu    = (in_mdu_op >= 3'd1) && (in_mdu_op <= 3'd4);
    assign is_mf     = (in_mdu_op == 3'd5) || (in_mdu_op == 3'd6);
    assign stall_out = (state_q != IDLE) && (is_mdu || is_mf) && !flush;
    assign accept    = (state_q == IDLE) && is_mdu && !flush && ctrl_clk_mips;
    assign op_signed = (in_mdu_op == 3'd1) || (in_mdu_op == 3'd3);
    assign sa        = op_signed & fwd_a[len-1];
    assign sb        = op_signed & fwd_b[len-1];
    assign alu_sel   = (in_mdu_op == 3'd5) ? hi_q : (in_mdu_op == 3'd6) ? lo_q : alu_res;
    assign wr_sel    = execute_bus[9] ? NB'(31) : execute_bus[8] ? in_rd : in_rt;
    assign mdu_busy  = (state_q != IDLE);

    // MDU: {acc,q} is the product shifting right, or remainder/quotient shifting left.
    always_comb begin
        state_d = state_q; cnt_d = cnt_q; acc_d = acc_q; q_d = q_q; m_d = m_q;
        div_d = div_q; neg_d = neg_q; rneg_d = rneg_q; dz_d = dz_q;
        hi_d = hi_q; lo_d = lo_q;
        sum     = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : {len{1'b0}})};
        shifted = {acc_q, q_q[len-1]};
        diff    = shifted - {1'b0, m_q};
        prod    = {acc_q, q_q};
        prod_n  = -prod;
        if (ctrl_clk_mips) begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d = RUN;
                    cnt_d   = CW'(len);
                    acc_d   = '0;
                    q_d     = sa ? -fwd_a : fwd_a;
                    m_d     = sb ? -fwd_b : fwd_b;
                    div_d   = (in_mdu_op == 3'd3) || (in_mdu_op == 3'd4);
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    dz_d    = (fwd_b == '0);
                end
                RUN: begin
                    if (div_q) begin
                        if (!diff[len]) begin
                            acc_d = diff[len-1:0];
                            q_d   = {q_q[len-2:0], 1'b1};
                        end else begin
                            acc_d = shifted[len-1:0];
                            q_d   = {q_q[len-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = sum[len:1];
                        q_d   = {sum[0], q_q[len-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = FIX;
                end
                FIX: begin
                    state_d = IDLE;
                    if (div_q) begin
                        lo_d = dz_q ? '1 : (neg_q ? -q_q : q_q);
                        hi_d = rneg_q ? -acc_q : acc_q;
                    end else begin
                        {hi_d, lo_d} = neg_q ? prod_n : prod;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [len-1:0]         pcb_q, pcb_d, alu_q, alu_d, reg2_q, reg2_d;
    logic                   zero_q, zero_d, halt_q, halt_d;
    logic [NB-1:0]          wr_q, wr_d;
    logic [len_mem_bus-1:0] mem_q, mem_d;
    logic [len_wb_bus-1:0]  wb_q, wb_d;

    always_comb begin
        pcb_d = pcb_q; alu_d = alu_q; reg2_d = reg2_q; zero_d = zero_q;
        halt_d = halt_q; wr_d = wr_q; mem_d = mem_q; wb_d = wb_q;
        if (ctrl_clk_mips) begin
            halt_d = halt_flag_e;
            if (flush) begin
                pcb_d = '0; alu_d = '0; reg2_d = '0; zero_d = 1'b0;
                wr_d = '0; mem_d = '0; wb_d = '0;
            end else if (stall_out) begin
                wr_d = '0; mem_d = '0; wb_d = '0;
            end else begin
                pcb_d  = in_pc_branch + in_sign_extend;
                alu_d  = alu_sel;
                reg2_d = fwd_b;
                zero_d = (alu_sel == '0);
                wr_d   = wr_sel;
                mem_d  = is_mdu ? '0 : memory_bus;
                wb_d   = is_mdu ? '0 : writeBack_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE; cnt_q <= '0; acc_q <= '0; q_q <= '0; m_q <= '0;
            div_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0;
            hi_q <= '0; lo_q <= '0;
            pcb_q <= '0; alu_q <= '0; reg2_q <= '0; zero_q <= 1'b0;
            halt_q <= 1'b0; wr_q <= '0; mem_q <= '0; wb_q <= '0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d; q_q <= q_d; m_q <= m_d;
            div_q <= div_d; neg_q <= neg_d; rneg_q <= rneg_d; dz_q <= dz_d;
            hi_q <= hi_d; lo_q <= lo_d;
            pcb_q <= pcb_d; alu_q <= alu_d; reg2_q <= reg2_d; zero_q <= zero_d;
            halt_q <= halt_d; wr_q <= wr_d; mem_q <= mem_d; wb_q <= wb_d;
        end
    end

    assign out_pc_branch     = pcb_q;
    assign out_alu           = alu_q;
    assign out_reg2          = reg2_q;
    assign zero_flag         = zero_q;
    assign out_write_reg     = wr_q;
    assign out_halt_flag_e   = halt_q;
    assign memory_bus_out    = mem_q;
    assign writeBack_bus_out = wb_q;
endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: stimulus pushes expected values into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_execute_mdu;
    logic        clk = 1'b0, reset = 1'b0, ctrl_clk_mips;
    logic [31:0] in_pc_branch, in_reg1, in_reg2, in_sign_extend, in_mem_forw, in_wb_forw;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt, rd_3_4, rd_4_5;
    logic [10:0] execute_bus;
    logic [8:0]  memory_bus;
    logic [1:0]  writeBack_bus;
    logic [2:0]  in_mdu_op;
    logic        register_write_3_4, register_write_4_5, flush, halt_flag_e;
    logic [31:0] out_pc_branch, out_alu, out_reg2;
    logic        zero_flag, out_halt_flag_e, stall_out, mdu_busy;
    logic [4:0]  out_write_reg;
    logic [8:0]  memory_bus_out;
    logic [1:0]  writeBack_bus_out;

    execute_mdu dut (
        .clk(clk), .reset(reset), .ctrl_clk_mips(ctrl_clk_mips),
        .in_pc_branch(in_pc_branch), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_sign_extend(in_sign_extend), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .execute_bus(execute_bus), .memory_bus(memory_bus),
        .writeBack_bus(writeBack_bus), .in_mdu_op(in_mdu_op),
        .register_write_3_4(register_write_3_4), .register_write_4_5(register_write_4_5),
        .rd_3_4(rd_3_4), .rd_4_5(rd_4_5), .in_mem_forw(in_mem_forw), .in_wb_forw(in_wb_forw),
        .flush(flush), .halt_flag_e(halt_flag_e), .out_pc_branch(out_pc_branch),
        .out_alu(out_alu), .out_reg2(out_reg2), .zero_flag(zero_flag),
        .out_write_reg(out_write_reg), .out_halt_flag_e(out_halt_flag_e),
        .memory_bus_out(memory_bus_out), .writeBack_bus_out(writeBack_bus_out),
        .stall_out(stall_out), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    localparam int S_ALU = 0, S_WR = 1, S_WB = 2, S_MEM = 3, S_BUSY = 4,
                   S_REG2 = 5, S_PCB = 6, S_ZERO = 7, S_HALT = 8, S_STALL = 9;
    localparam logic [10:0] E_RD = 11'h100, E_LINK = 11'h600, E_SH = 11'h080;

    typedef struct { string name; int sel; logic [31:0] exp; } exp_t;
    exp_t sb[$];
    int   n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                S_ALU:   act = out_alu;
                S_WR:    act = 32'(out_write_reg);
                S_WB:    act = 32'(writeBack_bus_out);
                S_MEM:   act = 32'(memory_bus_out);
                S_BUSY:  act = 32'(mdu_busy);
                S_REG2:  act = out_reg2;
                S_PCB:   act = out_pc_branch;
                S_ZERO:  act = 32'(zero_flag);
                S_HALT:  act = 32'(out_halt_flag_e);
                default: act = 32'(stall_out);
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        ctrl_clk_mips = 1'b1; flush = 1'b0; halt_flag_e = 1'b0;
        in_pc_branch = '0; in_reg1 = '0; in_reg2 = '0; in_sign_extend = '0;
        in_mem_forw = '0; in_wb_forw = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; rd_3_4 = '0; rd_4_5 = '0; execute_bus = '0; memory_bus = '0;
        writeBack_bus = '0; in_mdu_op = 3'd0;
        register_write_3_4 = 1'b0; register_write_4_5 = 1'b0;
    endtask

    // Issue an MDU op, then MFLO (waits out the stall) and MFHI.
    task automatic mdu_run(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input bit freeze);
        int n;
        idle_in();
        in_mdu_op = op; in_rs = 5'd1; in_rt = 5'd2; in_reg1 = a; in_reg2 = b;
        writeBack_bus = 2'b01;
        tick();
        expect_v({nm, "_busy"}, S_BUSY, 1);
        expect_v({nm, "_bubble_wb"}, S_WB, 0);
        idle_in();
        in_mdu_op = 3'd6; execute_bus = E_RD; in_rd = 5'd8; writeBack_bus = 2'b01;
        n = 0;
        while (stall_out && n < 200) begin
            ctrl_clk_mips = !(freeze && n >= 10 && n < 15);
            n++;
            tick();
        end
        ctrl_clk_mips = 1'b1;
        check({nm, "_stall_cycles"}, n, freeze ? 38 : 33);
        expect_v({nm, "_stall_wb"}, S_WB, 0);
        tick();
        expect_v({nm, "_mflo"}, S_ALU, exp_lo);
        expect_v({nm, "_mflo_wr"}, S_WR, 8);
        expect_v({nm, "_mflo_wb"}, S_WB, 1);
        in_mdu_op = 3'd5;
        tick();
        expect_v({nm, "_mfhi"}, S_ALU, exp_hi);
    endtask

    initial begin
        idle_in();
        reset = 1'b0;
        tick(); tick();
        expect_v("rst_alu", S_ALU, 0);
        expect_v("rst_busy", S_BUSY, 0);
        expect_v("rst_wb", S_WB, 0);
        expect_v("rst_pcb", S_PCB, 0);
        @(negedge clk); #1;
        reset = 1'b1;

        // ADD with rs forwarded from EX/MEM
        idle_in();
        execute_bus = E_RD; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
        in_reg1 = 5; in_reg2 = 9; register_write_3_4 = 1'b1; rd_3_4 = 5'd1;
        in_mem_forw = 100; in_pc_branch = 32'h100; in_sign_extend = 32'h10;
        writeBack_bus = 2'b01; memory_bus = 9'h1A5; halt_flag_e = 1'b1;
        tick();
        expect_v("add_alu", S_ALU, 109);
        expect_v("add_wr", S_WR, 3);
        expect_v("add_wb", S_WB, 1);
        expect_v("add_mem", S_MEM, 9'h1A5);
        expect_v("add_reg2", S_REG2, 9);
        expect_v("add_pcb", S_PCB, 32'h110);
        expect_v("add_zero", S_ZERO, 0);
        expect_v("add_halt", S_HALT, 1);

        // SUB: A from EX/MEM, B from MEM/WB
        idle_in();
        execute_bus = 11'h001; in_rs = 5'd4; in_rt = 5'd5; in_reg1 = 1; in_reg2 = 2;
        register_write_3_4 = 1'b1; rd_3_4 = 5'd4; in_mem_forw = 50;
        register_write_4_5 = 1'b1; rd_4_5 = 5'd5; in_wb_forw = 70;
        tick();
        expect_v("sub_alu", S_ALU, 32'hFFFFFFEC);
        expect_v("sub_reg2", S_REG2, 70);
        expect_v("sub_wr", S_WR, 5);
        expect_v("sub_halt", S_HALT, 0);

        // EX/MEM wins over MEM/WB for the same register
        idle_in();
        in_rs = 5'd4; register_write_3_4 = 1'b1; rd_3_4 = 5'd4; in_mem_forw = 50;
        register_write_4_5 = 1'b1; rd_4_5 = 5'd4; in_wb_forw = 70;
        tick();
        expect_v("fwd_prio", S_ALU, 50);

        // register 0 is never forwarded
        idle_in();
        in_reg1 = 3; in_reg2 = 4; register_write_3_4 = 1'b1; in_mem_forw = 99;
        tick();
        expect_v("r0_nofwd", S_ALU, 7);

        // zero flag
        idle_in();
        execute_bus = 11'h001; in_rs = 5'd6; in_rt = 5'd7; in_reg1 = 12; in_reg2 = 12;
        tick();
        expect_v("zero_set", S_ZERO, 1);

        // SLL by shamt
        idle_in();
        execute_bus = E_SH | 11'h008; in_shamt = 5'd4; in_rt = 5'd2; in_reg2 = 1;
        tick();
        expect_v("sll", S_ALU, 16);

        // link
        idle_in();
        execute_bus = E_LINK; in_pc_branch = 32'h40;
        tick();
        expect_v("link_alu", S_ALU, 32'h41);
        expect_v("link_wr", S_WR, 31);

        mdu_run("mult", 3'd1, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        mdu_run("div", 3'd3, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        mdu_run("div0s", 3'd3, 32'hFFFFFFFB, 0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
        mdu_run("divu0", 3'd4, 32'h80000000, 0, 32'hFFFFFFFF, 32'h80000000, 1'b0);

        // flushed MULT is not accepted and clears outputs except halt
        idle_in();
        in_mdu_op = 3'd1; in_rs = 5'd1; in_rt = 5'd2; in_reg1 = 5; in_reg2 = 6;
        execute_bus = E_RD; in_rd = 5'd3; writeBack_bus = 2'b01; memory_bus = 9'h1FF;
        flush = 1'b1; halt_flag_e = 1'b1;
        expect_v("flush_nostall", S_STALL, 0);
        tick();
        expect_v("flush_busy", S_BUSY, 0);
        expect_v("flush_alu", S_ALU, 0);
        expect_v("flush_wb", S_WB, 0);
        expect_v("flush_mem", S_MEM, 0);
        expect_v("flush_wr", S_WR, 0);
        expect_v("flush_halt", S_HALT, 1);
        idle_in();
        in_mdu_op = 3'd5;
        tick();
        expect_v("flush_hi_kept", S_ALU, 32'h80000000);
        in_mdu_op = 3'd6;
        tick();
        expect_v("flush_lo_kept", S_ALU, 32'hFFFFFFFF);

        // async reset in the middle of RUN
        idle_in();
        in_mdu_op = 3'd1; in_rs = 5'd1; in_rt = 5'd2; in_reg1 = 9; in_reg2 = 9;
        tick();
        idle_in();
        execute_bus = 11'h000; in_reg1 = 32'h55;
        repeat (10) tick();
        expect_v("run_busy", S_BUSY, 1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        expect_v("rst_mid_busy", S_BUSY, 0);
        expect_v("rst_mid_alu", S_ALU, 0);
        expect_v("rst_mid_wb", S_WB, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        idle_in();
        in_mdu_op = 3'd6;
        tick();
        expect_v("rst_lo", S_ALU, 0);
        expect_v("rst_stall", S_STALL, 0);
        in_mdu_op = 3'd5; in_reg1 = 1;
        tick();
        expect_v("rst_hi", S_ALU, 0);

        mdu_run("freeze", 3'd1, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b1);

        idle_in();
        tick();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
- Parametrised successor of the MIPS execute stage (ID/EX → EX/MEM).
- Keeps the ALU, the two-level forwarding, the destination-register select, flush and halt pass-through.
- Adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a stall handshake toward the hazard/PC logic.
- MULT/MULTU/DIV/DIVU run for len+1 cycles in the background; MFHI/MFLO and any new MDU op stall upstream until the result is ready.

Parameters:
- len, 32, datapath width (even, ≥8)
- NB, $clog2(len), register-index width
- len_exec_bus, 11, execute control bus width: [3:0] ALU opcode, [6] imm src, [7] shamt src, [8] rd dest, [9] link r31, [10] link pc
- len_mem_bus, 9, memory control bus width
- len_wb_bus, 2, write-back control bus width; bit [0] = register write

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ctrl_clk_mips  in  1  pipeline advance enable; low freezes every register, including MDU state
- in_pc_branch, in_reg1, in_reg2, in_sign_extend  in  len each  ID/EX operands
- in_rs, in_rt, in_rd, in_shamt  in  NB each  register fields
- execute_bus, memory_bus, writeBack_bus  in  len_exec_bus/len_mem_bus/len_wb_bus  control buses
- in_mdu_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none
- register_write_3_4, register_write_4_5  in  1 each  forwarding write flags
- rd_3_4, rd_4_5  in  NB each  forwarding destinations
- in_mem_forw, in_wb_forw  in  len each  forwarded values
- flush, halt_flag_e  in  1 each  bubble request; halt flag
- out_pc_branch, out_alu, out_reg2  out  len each  registered results
- zero_flag  out  1  registered ALU zero
- out_write_reg  out  NB  registered destination
- out_halt_flag_e  out  1  registered halt
- memory_bus_out, writeBack_bus_out  out  len_mem_bus/len_wb_bus  registered control
- stall_out  out  1  combinational: hold IF/ID/ID-EX this cycle
- mdu_busy  out  1  registered: MDU state ≠ IDLE

Behaviour:
- Reset (reset=0, async): all registered outputs = 0; HI = LO = 0; MDU state = IDLE; counter = 0.

Forwarding (per operand, rs→A, rt→B; operand register 0 is never forwarded):
- register_write_3_4 && rd_3_4 == reg → in_mem_forw.
- Else register_write_4_5 && rd_4_5 == reg → in_wb_forw.
- Else the register-file value.

ALU operands:
- A = bit10 ? pc : bit7 ? zero-extended shamt : fwdA.
- B = bit10 ? 1 : bit6 ? sign_extend : fwdB.
- out_reg2 carries the forwarded B value (fwdB).
- out_write_reg = bit9 ? 31 : bit8 ? rd : rt.
- out_pc_branch = in_pc_branch + in_sign_extend.
- MFHI/MFLO: out_alu = HI/LO instead of the ALU result.

stall_out:
- Asserted when state ≠ IDLE and in_mdu_op ∈ {001..110} and flush = 0.

Output register update, only when ctrl_clk_mips = 1:
- flush → all outputs except the halt flag cleared.
- stall_out → bubble: memory_bus_out, writeBack_bus_out, out_write_reg = 0; other outputs hold.
- Otherwise normal capture.
- out_halt_flag_e <= halt_flag_e whenever ctrl_clk_mips = 1.

MDU state machine: IDLE → RUN → FIX → IDLE.
- IDLE:
  - An MDU op (001..100) with no flush and ctrl_clk_mips = 1 latches fwdA/fwdB as operand magnitudes (signed ops: absolute values plus result-sign bits).
  - Counter is set to len; state → RUN.
  - The instruction itself leaves as a bubble (writeBack_bus_out = 0).
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per enabled cycle.
  - Counter decrements; at 1 → FIX.
- FIX:
  - Apply signs: product is two's-complement 2·len; quotient sign = sA^sB; remainder sign = sA.
  - Write HI/LO; state → IDLE.
  - A waiting MFHI/MFLO is released in the next cycle and reads the new value.
- Completion is len+1 enabled cycles after acceptance.
- Divide by zero: LO = all ones, HI = dividend (signed: original fwdA); no exception.
- flush does not abort a running operation; a flushed MDU op is never accepted.
- Reset mid-RUN returns to IDLE with HI = LO = 0.
- Simultaneous FIX and stalled request: the request is stalled this cycle and accepted the next.

Test Plan:
- ADD r3 with in_reg1=5, in_reg2=9, register_write_3_4=1, rd_3_4=rs, in_mem_forw=100 → out_alu=109.
- MULT fwdA=7, fwdB=0xFFFFFFFD, then MFLO → stall_out high 33 cycles; MFLO out_alu=0xFFFFFFEB; a following MFHI → 0xFFFFFFFF.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x80000000/0 → LO=0xFFFFFFFF, HI=0x80000000.
- MULT presented with flush=1 → mdu_busy stays 0; HI/LO unchanged; outputs zero.
- reset pulsed low at RUN cycle 10 → mdu_busy=0, HI=LO=0, all outputs 0 immediately; ctrl_clk_mips=0 for 5 cycles during RUN → counter frozen, completion delayed exactly 5 cycles.
- link instruction (bit10=1, bit9=1, pc=0x40) → out_alu=0x41, out_write_reg=31.
